// File: rtl/hash_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency hash pipeline between
// NUM_REQ requesters, with tag tracking, pause/drain and tag checking.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_addr/req_ready   requester side (ready is a one-hot grant)
//   hash_in_valid/hash_in_addr     issue to hash unit
//   hash_out_valid/hash_out_addr   results from hash unit
//   resp_valid/resp_addr           one-hot result strobe and address
//   pause_req/paused               quiesce control
//   inflight                       accepted-but-not-responded count
//   tag_err                        sticky tag/address mismatch
module hash_pipe_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_SIZE    = 22,
   parameter int HASH_LATENCY = 6,
   parameter int REQ_ID_SIZE  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   parameter int CNT_W        = $clog2(HASH_LATENCY + 3) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         hash_in_valid,
   output logic [ADDR_SIZE-1:0]         hash_in_addr,
   input  logic                         hash_out_valid,
   input  logic [ADDR_SIZE-1:0]         hash_out_addr,
   output logic [NUM_REQ-1:0]           resp_valid,
   output logic [ADDR_SIZE-1:0]         resp_addr,
   input  logic                         pause_req,
   output logic                         paused,
   output logic [CNT_W-1:0]             inflight,
   output logic                         tag_err
);

   typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

   state_t                   state, state_d;
   logic [REQ_ID_SIZE-1:0]   rr_ptr;
   logic [REQ_ID_SIZE-1:0]   gnt_id;
   logic [ADDR_SIZE-1:0]     gnt_addr;
   logic                     hs;
   logic [REQ_ID_SIZE-1:0]   iss_id;

   logic                     tag_v  [HASH_LATENCY];
   logic [REQ_ID_SIZE-1:0]   tag_id [HASH_LATENCY];
   logic [ADDR_SIZE-1:0]     tag_a  [HASH_LATENCY];

   logic                     tail_v;
   logic [REQ_ID_SIZE-1:0]   tail_id;
   logic [ADDR_SIZE-1:0]     tail_a;

   assign tail_v  = tag_v[HASH_LATENCY-1];
   assign tail_id = tag_id[HASH_LATENCY-1];
   assign tail_a  = tag_a[HASH_LATENCY-1];

   // Scan from rr_ptr upward; rst_n gating keeps ready low in reset.
   always_comb begin
      int  idx;
      logic found;
      req_ready = '0;
      gnt_id    = '0;
      gnt_addr  = '0;
      found     = 1'b0;
      idx       = 0;
      if (rst_n && state == RUN && !pause_req) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
               found          = 1'b1;
               req_ready[idx] = 1'b1;
               gnt_id         = REQ_ID_SIZE'(idx);
               gnt_addr       = req_addr[idx*ADDR_SIZE +: ADDR_SIZE];
            end
         end
      end
   end

   assign hs = |(req_ready & req_valid);

   always_comb begin
      state_d = state;
      unique case (state)
         RUN:    if (pause_req) state_d = DRAIN;
         DRAIN:  if (!pause_req) state_d = RUN;
                 else if (inflight == '0) state_d = PAUSED;
         PAUSED: if (!pause_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RUN;
         paused        <= 1'b0;
         rr_ptr        <= '0;
         hash_in_valid <= 1'b0;
         hash_in_addr  <= '0;
         iss_id        <= '0;
      end else begin
         state         <= state_d;
         paused        <= (state_d == PAUSED);
         hash_in_valid <= hs;
         if (hs) begin
            rr_ptr       <= REQ_ID_SIZE'((int'(gnt_id) + 1) % NUM_REQ);
            hash_in_addr <= gnt_addr;
            iss_id       <= gnt_id;
         end
      end
   end

   // Fed from the issue registers so the tail lines up with hash_out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HASH_LATENCY; i++) begin
            tag_v[i]  <= 1'b0;
            tag_id[i] <= '0;
            tag_a[i]  <= '0;
         end
      end else begin
         tag_v[0]  <= hash_in_valid;
         tag_id[0] <= iss_id;
         tag_a[0]  <= hash_in_addr;
         for (int i = 1; i < HASH_LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
            tag_a[i]  <= tag_a[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= '0;
         resp_addr  <= '0;
         tag_err    <= 1'b0;
         inflight   <= '0;
      end else begin
         resp_valid <= '0;
         if (hash_out_valid && tail_v) begin
            resp_valid <= NUM_REQ'(1) << tail_id;
            resp_addr  <= hash_out_addr;
         end
         if ((tail_v != hash_out_valid) ||
             (tail_v && hash_out_valid && tail_a != hash_out_addr))
            tag_err <= 1'b1;
         unique case ({hs, |resp_valid})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_pipe_arbiter.sv
// Directed bench for hash_pipe_arbiter with a 6-cycle hash unit model
// and fault injection on the hash output.
module tb_hash_pipe_arbiter;

   localparam int N  = 2;
   localparam int AW = 22;
   localparam int L  = 6;
   localparam int CW = $clog2(L + 3) + 1;

   logic          clk = 0;
   logic          rst_n = 0;
   logic [N-1:0]  req_valid = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N-1:0]  req_ready;
   logic          hash_in_valid;
   logic [AW-1:0] hash_in_addr;
   logic          hash_out_valid;
   logic [AW-1:0] hash_out_addr;
   logic [N-1:0]  resp_valid;
   logic [AW-1:0] resp_addr;
   logic          pause_req = 0;
   logic          paused;
   logic [CW-1:0] inflight;
   logic          tag_err;

   logic          hv [L];
   logic [AW-1:0] ha [L];
   logic [AW-1:0] flip = '0;
   logic          inj = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hash_pipe_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready),
      .hash_in_valid(hash_in_valid), .hash_in_addr(hash_in_addr),
      .hash_out_valid(hash_out_valid), .hash_out_addr(hash_out_addr),
      .resp_valid(resp_valid), .resp_addr(resp_addr),
      .pause_req(pause_req), .paused(paused),
      .inflight(inflight), .tag_err(tag_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < L; i++) begin
            hv[i] <= 1'b0;
            ha[i] <= '0;
         end
      end else begin
         hv[0] <= hash_in_valid;
         ha[0] <= hash_in_addr;
         for (int i = 1; i < L; i++) begin
            hv[i] <= hv[i-1];
            ha[i] <= ha[i-1];
         end
      end
   end

   assign hash_out_valid = hv[L-1] | inj;
   assign hash_out_addr  = ha[L-1] ^ flip;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      req_valid = '0;
      req_addr = '0;
      pause_req = 0;
      flip = '0;
      inj = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_hiv", 32'(hash_in_valid), 0);
      chk("rst_inf", 32'(inflight), 0);
      chk("rst_paused", 32'(paused), 0);
      chk("rst_err", 32'(tag_err), 0);

      // single request
      for (int c = 0; c < 13; c++) begin
         cyc();
         req_valid = (c == 0) ? 2'b01 : 2'b00;
         req_addr[0 +: AW] = 22'h12345;
         #1;
         if (c == 0) chk("t1_rdy", 32'(req_ready), 1);
         if (c == 1) begin
            chk("t1_hiv", 32'(hash_in_valid), 1);
            chk("t1_hia", 32'(hash_in_addr), 32'h12345);
         end
         chk("t1_inf", 32'(inflight), (c >= 1 && c <= 8) ? 1 : 0);
         chk("t1_rv", 32'(resp_valid), (c == 8) ? 1 : 0);
         if (c == 8) chk("t1_ra", 32'(resp_addr), 32'h12345);
      end
      chk("t1_err", 32'(tag_err), 0);

      // both requesters, alternating grants
      do_reset();
      for (int c = 0; c < 17; c++) begin
         cyc();
         req_valid = (c < 8) ? 2'b11 : 2'b00;
         req_addr = {22'h00002, 22'h00001};
         #1;
         chk("t2_rdy", 32'(req_ready),
             (c < 8) ? ((c % 2) ? 2 : 1) : 0);
         chk("t2_rv", 32'(resp_valid),
             (c >= 8 && c < 16) ? (((c - 8) % 2) ? 2 : 1) : 0);
         if (c >= 8 && c < 16)
            chk("t2_ra", 32'(resp_addr), ((c - 8) % 2) ? 2 : 1);
         if (c == 8) chk("t2_peak", 32'(inflight), 8);
      end

      // requester 1 streaming 20 requests
      do_reset();
      for (int c = 0; c < 30; c++) begin
         cyc();
         req_valid = (c < 20) ? 2'b10 : 2'b00;
         req_addr[AW +: AW] = AW'(32'h100 + c);
         #1;
         chk("t3_rdy", 32'(req_ready), (c < 20) ? 2 : 0);
         chk("t3_rv", 32'(resp_valid), (c >= 8 && c < 28) ? 2 : 0);
         if (c >= 8 && c < 28)
            chk("t3_ra", 32'(resp_addr), 32'h100 + c - 8);
      end
      chk("t3_inf", 32'(inflight), 0);

      // pause with 5 in flight
      do_reset();
      for (int c = 0; c < 18; c++) begin
         cyc();
         req_valid = 2'b01;
         req_addr[0 +: AW] = AW'(32'h200 + c);
         pause_req = (c >= 5 && c < 15);
         #1;
         if (c < 5 || c >= 16) chk("t4_rdy", 32'(req_ready), 1);
         else chk("t4_hold", 32'(req_ready), 0);
         if (c == 5) chk("t4_inf5", 32'(inflight), 5);
         chk("t4_rv", 32'(resp_valid), (c >= 8 && c < 13) ? 1 : 0);
         if (c >= 8 && c < 13)
            chk("t4_ra", 32'(resp_addr), 32'h200 + c - 8);
         chk("t4_paused", 32'(paused), (c == 14 || c == 15) ? 1 : 0);
      end

      // tail address bit flip
      do_reset();
      for (int c = 0; c < 12; c++) begin
         cyc();
         req_valid = (c == 0) ? 2'b01 : 2'b00;
         req_addr[0 +: AW] = 22'h12345;
         flip = (c == 7) ? 22'h1 : 22'h0;
         #1;
         chk("t5_err", 32'(tag_err), (c >= 8) ? 1 : 0);
         if (c == 8) begin
            chk("t5_rv", 32'(resp_valid), 1);
            chk("t5_ra", 32'(resp_addr), 32'h12344);
         end
      end

      // spurious hash_out_valid with empty tail
      do_reset();
      for (int c = 0; c < 7; c++) begin
         cyc();
         inj = (c == 3);
         #1;
         chk("t5b_err", 32'(tag_err), (c >= 4) ? 1 : 0);
         chk("t5b_rv", 32'(resp_valid), 0);
      end

      // reset with 4 in flight
      do_reset();
      for (int c = 0; c < 6; c++) begin
         cyc();
         req_valid = (c < 4) ? 2'b01 : 2'b00;
         req_addr[0 +: AW] = 22'h3aaaa;
      end
      #1;
      chk("t6_pre", 32'(inflight), 4);
      cyc();
      req_valid = 2'b01;
      rst_n = 0;
      #1;
      chk("t6_rdy", 32'(req_ready), 0);
      chk("t6_hiv", 32'(hash_in_valid), 0);
      chk("t6_hia", 32'(hash_in_addr), 0);
      chk("t6_inf", 32'(inflight), 0);
      chk("t6_rv", 32'(resp_valid), 0);
      chk("t6_ra", 32'(resp_addr), 0);
      cyc();
      req_valid = '0;
      rst_n = 1;
      for (int c = 0; c < 12; c++) begin
         cyc();
         #1;
         chk("t6_norv", 32'(resp_valid), 0);
         chk("t6_noinf", 32'(inflight), 0);
      end
      chk("t6_err", 32'(tag_err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
